sira_istatistik_birimi: RTL and testbench
=========================================

// Module: sira_istatistik_birimi
// PURPOSE
//  Parametrised order-statistic (rank) filter; successor of the fixed 9-sample median unit.
//  Accepts one PIXEL_BIT sample per etkin_i cycle and keeps an insertion-sorted window of PENCERE samples.
//  Returns the element at a run-time rank (min/median/max/any).
//  Two modes: blok (one result per PENCERE samples) and kayan (sliding; one result per sample once full).
//  Sits in the pixel filter pipeline between the window fetcher and the output writer.
// PARAMETERS
//  PIXEL_BIT  8  sample width, unsigned
//  PENCERE    9  window length, 3..25
//  SIRA_BIT   $clog2(PENCERE)  width of rank select
// PORTS
//  clk_i      in   1          single clock, rising edge
//  rst_i      in   1          synchronous reset, active-high
//  etkin_i    in   1          sample valid; sayi_i is accepted at every rising edge with etkin_i=1
//  sayi_i     in   PIXEL_BIT  sample
//  sira_i     in   SIRA_BIT   requested rank (0=min); values >= PENCERE clamp to PENCERE-1
//  kip_i      in   1          0=KIP_BLOK, 1=KIP_KAYAN
//  temizle_i  in   1          synchronous flush of window contents
//  sonuc_o    out  PIXEL_BIT  selected order statistic
//  hazir_o    out  1          1-cycle pulse; sonuc_o valid
//  dolu_o     out  1          window holds PENCERE samples
// BEHAVIOUR
//  Reset (rst_i=1 at an edge): sorted array, history, count <= 0; sonuc_o=0, hazir_o=0, dolu_o=0. Overrides all inputs.
//  Priority at an edge: rst_i > temizle_i > etkin_i.
//  temizle_i: count <= 0; hazir_o <= 0. A same-cycle sample is dropped. Array contents are don't-care.
//  Mode: kip_i is latched at the edge accepting the first sample after reset/flush/blok-completion.
//   It is ignored while count>0.
//  Insert: sample goes after all existing equal values (stable); 1 sample/cycle, no stall, no back-pressure.
//  Blok: count 0..PENCERE-1 increments on each accept.
//   At the accept making count==PENCERE:
//    - capture rank = min(sira_i, PENCERE-1);
//    - at the next edge: sonuc_o <= sorted[rank], hazir_o <= 1 for one cycle;
//    - count returns to 0 (window restarts; the next sample may arrive in the very next cycle).
//  Kayan: samples are also written to a circular history (wr pointer wraps at PENCERE-1 -> 0).
//   Until full, behaves like blok filling.
//   When full, each accept removes the first sorted entry equal to the oldest history value
//   and inserts the new sample in the same edge.
//   The result is produced one edge later (hazir_o every accepted sample).
//   dolu_o stays 1 until flush/reset.
//  Latency: 1 cycle from the accepting edge to hazir_o=1. Gaps (etkin_i=0) freeze all state; hazir_o=0 in idle cycles.
//  hazir_o is never asserted for a partial window. sira_i is sampled only at result-producing accepts.
//  Unsigned compare only; no arithmetic widening. Count width $clog2(PENCERE+1).
// STRUCTURE
//  Shared constants in sabitler.vh: PIXEL_BIT, KIP_BLOK=1'b0, KIP_KAYAN=1'b1.
//  Sub-module sirali_dizi:
//   - PENCERE-entry parallel compare-shift register array;
//   - ports: ekle, sil, sil_deger, yeni_deger, and flat sorted-array output;
//   - insert and remove in one cycle.
//  Top level holds the count, mode latch, history ring, rank clamp and the output register.
// TESTING
//  Blok, sira=4, feed 7,7,1,1,1,2,2,9,8 back-to-back -> one hazir_o pulse, sonuc_o=2; dolu_o pulses 1 then 0.
//  Same window, sira=0 then sira=8 (two windows) -> 1 then 9; sira=15 clamps -> 9.
//  Same window with etkin_i=0 for 2 cycles after sample 5 -> identical result 2, hazir_o not asserted in gaps.
//  Kayan, sira=4, feed 7,7,1,1,1,2,2,9,8,0,9 -> hazir_o after 9th, 10th and 11th sample.
//   sonuc_o: 2 (window 1,1,1,2,2,7,7,8,9), 2 (0,1,1,1,2,2,7,8,9), 2 (0,1,1,1,2,2,8,9,9).
//  temizle_i after 5 samples, then 9,9,9,9,9,5,5,5,5 -> sonuc_o=5; asserting temizle_i together with etkin_i drops that sample.
//  rst_i mid-window (count=6) -> next cycle all outputs 0; a new 9-sample window yields the correct median with no carry-over.

Source files
------------

// File: rtl/sira_istatistik_birimi_pkg.sv
// Shared types and constants for the order-statistic (rank) filter.
package sira_istatistik_birimi_pkg;

  typedef enum logic {
    KIP_BLOK  = 1'b0,
    KIP_KAYAN = 1'b1
  } kip_e;

  localparam int PIXEL_BIT_VARSAYILAN = 8;
  localparam int PENCERE_VARSAYILAN   = 9;

  function automatic int sayac_genisligi(input int pencere);
    return $clog2(pencere + 1);
  endfunction

endpackage

// File: rtl/sira_istatistik_birimi_sirali_dizi.sv
// Insertion-sorted sample array: removes one matching entry and inserts a new one in the same cycle.
// sirali_o shows the contents as they will be after the current edge.
module sirali_dizi
  import sira_istatistik_birimi_pkg::*;
#(
  parameter int PIXEL_BIT = PIXEL_BIT_VARSAYILAN,
  parameter int PENCERE   = PENCERE_VARSAYILAN
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         bosalt_i,
  input  logic                         ekle_i,
  input  logic                         sil_i,
  input  logic [PIXEL_BIT-1:0]         sil_deger_i,
  input  logic [PIXEL_BIT-1:0]         yeni_deger_i,
  output logic [PENCERE*PIXEL_BIT-1:0] sirali_o
);

  logic [PIXEL_BIT-1:0] dizi_q   [PENCERE];
  logic [PENCERE-1:0]   gecerli_q;
  logic [PIXEL_BIT-1:0] dizi_d   [PENCERE];
  logic [PENCERE-1:0]   gecerli_d;

  logic [PIXEL_BIT-1:0] ham      [PENCERE+1];
  logic [PENCERE:0]     ham_g;
  logic [PIXEL_BIT-1:0] silinmis [PENCERE];
  logic [PENCERE-1:0]   silinmis_g;
  logic [PIXEL_BIT-1:0] kaydir   [PENCERE];
  logic [PENCERE-1:0]   kaydir_g;
  logic [PENCERE:0]     kucuk_esit;
  logic                 bulundu;

  // Removal: every entry at or above the first match takes its upper neighbour.
  always_comb begin
    bulundu       = 1'b0;
    ham[PENCERE]  = '0;
    ham_g[PENCERE] = 1'b0;
    for (int i = 0; i < PENCERE; i++) begin
      ham[i]   = dizi_q[i];
      ham_g[i] = gecerli_q[i];
    end
    for (int i = 0; i < PENCERE; i++) begin
      silinmis[i]   = ham[i];
      silinmis_g[i] = ham_g[i];
      if (sil_i) begin
        if (!bulundu && ham_g[i] && (ham[i] == sil_deger_i)) begin
          bulundu = 1'b1;
        end
        if (bulundu) begin
          silinmis[i]   = ham[i+1];
          silinmis_g[i] = ham_g[i+1];
        end
      end
    end
  end

  // Insertion after all entries <= new value keeps equal samples in arrival order.
  always_comb begin
    kucuk_esit[0] = 1'b1;
    kaydir[0]     = '0;
    kaydir_g[0]   = 1'b0;
    for (int i = 0; i < PENCERE; i++) begin
      kucuk_esit[i+1] = silinmis_g[i] && (silinmis[i] <= yeni_deger_i);
    end
    for (int i = 1; i < PENCERE; i++) begin
      kaydir[i]   = silinmis[i-1];
      kaydir_g[i] = silinmis_g[i-1];
    end
    for (int i = 0; i < PENCERE; i++) begin
      if (!ekle_i || kucuk_esit[i+1]) begin
        dizi_d[i]    = silinmis[i];
        gecerli_d[i] = silinmis_g[i];
      end else if (kucuk_esit[i]) begin
        dizi_d[i]    = yeni_deger_i;
        gecerli_d[i] = 1'b1;
      end else begin
        dizi_d[i]    = kaydir[i];
        gecerli_d[i] = kaydir_g[i];
      end
    end
  end

  always_comb begin
    sirali_o = '0;
    for (int i = 0; i < PENCERE; i++) begin
      sirali_o[i*PIXEL_BIT +: PIXEL_BIT] = dizi_d[i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || bosalt_i) begin
      gecerli_q <= '0;
    end else begin
      gecerli_q <= gecerli_d;
    end
    for (int i = 0; i < PENCERE; i++) begin
      dizi_q[i] <= dizi_d[i];
    end
  end

endmodule

// File: rtl/sira_istatistik_birimi.sv
// Order-statistic filter top: sample count, mode latch, history ring, rank clamp and result register.
// Block mode yields one result per window; sliding mode yields one per sample once full.
module sira_istatistik_birimi
  import sira_istatistik_birimi_pkg::*;
#(
  parameter int PIXEL_BIT = PIXEL_BIT_VARSAYILAN,
  parameter int PENCERE   = PENCERE_VARSAYILAN,
  parameter int SIRA_BIT  = $clog2(PENCERE)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 etkin_i,
  input  logic [PIXEL_BIT-1:0] sayi_i,
  input  logic [SIRA_BIT-1:0]  sira_i,
  input  logic                 kip_i,
  input  logic                 temizle_i,
  output logic [PIXEL_BIT-1:0] sonuc_o,
  output logic                 hazir_o,
  output logic                 dolu_o
);

  localparam int SAYAC_W = sayac_genisligi(PENCERE);
  localparam int PTR_W   = $clog2(PENCERE);
  localparam logic [SAYAC_W-1:0]  SAYAC_DOLU = SAYAC_W'(PENCERE);
  localparam logic [SAYAC_W-1:0]  SAYAC_SON  = SAYAC_W'(PENCERE - 1);
  localparam logic [PTR_W-1:0]    PTR_SON    = PTR_W'(PENCERE - 1);
  localparam logic [SIRA_BIT-1:0] SIRA_SON   = SIRA_BIT'(PENCERE - 1);

  function automatic logic [SIRA_BIT-1:0] sira_sikistir(input logic [SIRA_BIT-1:0] s);
    return (s > SIRA_SON) ? SIRA_SON : s;
  endfunction

  logic [SAYAC_W-1:0]         sayac_q, sayac_d;
  kip_e                       kip_q, kip_d;
  logic [PTR_W-1:0]           ptr_q, ptr_d;
  logic [PIXEL_BIT-1:0]       tarihce_q [PENCERE];
  logic [PIXEL_BIT-1:0]       sonuc_q, sonuc_d;
  logic                       hazir_q, hazir_d;
  logic                       dolu_q, dolu_d;

  logic                       kabul;
  logic                       son_ornek;
  logic                       kayan_tam;
  logic                       tamamla_blok;
  logic [SIRA_BIT-1:0]        sira_w;
  logic [PENCERE*PIXEL_BIT-1:0] sirali_w;

  // In sliding mode the write pointer slot holds the oldest sample once the ring is full.
  sirali_dizi #(
    .PIXEL_BIT (PIXEL_BIT),
    .PENCERE   (PENCERE)
  ) u_sirali_dizi (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .bosalt_i     (temizle_i || tamamla_blok),
    .ekle_i       (kabul),
    .sil_i        (kayan_tam),
    .sil_deger_i  (tarihce_q[ptr_q]),
    .yeni_deger_i (sayi_i),
    .sirali_o     (sirali_w)
  );

  always_comb begin
    kabul        = etkin_i && !temizle_i;
    son_ornek    = kabul && (sayac_q == SAYAC_SON);
    kayan_tam    = kabul && (sayac_q == SAYAC_DOLU);
    tamamla_blok = son_ornek && (kip_q == KIP_BLOK);
    sira_w       = sira_sikistir(sira_i);

    sayac_d = sayac_q;
    kip_d   = kip_q;
    ptr_d   = ptr_q;
    if (temizle_i) begin
      sayac_d = '0;
      ptr_d   = '0;
    end else if (kabul) begin
      if (sayac_q == '0) begin
        kip_d = kip_e'(kip_i);
      end
      ptr_d = (ptr_q == PTR_SON) ? '0 : ptr_q + 1'b1;
      if (tamamla_blok) begin
        sayac_d = '0;
      end else if (!kayan_tam) begin
        sayac_d = sayac_q + 1'b1;
      end
    end

    hazir_d = son_ornek || kayan_tam;
    dolu_d  = (sayac_d == SAYAC_DOLU) || tamamla_blok;
    sonuc_d = hazir_d ? sirali_w[int'(sira_w)*PIXEL_BIT +: PIXEL_BIT] : sonuc_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sayac_q <= '0;
      kip_q   <= KIP_BLOK;
      ptr_q   <= '0;
      sonuc_q <= '0;
      hazir_q <= 1'b0;
      dolu_q  <= 1'b0;
      for (int i = 0; i < PENCERE; i++) begin
        tarihce_q[i] <= '0;
      end
    end else begin
      sayac_q <= sayac_d;
      kip_q   <= kip_d;
      ptr_q   <= ptr_d;
      sonuc_q <= sonuc_d;
      hazir_q <= hazir_d;
      dolu_q  <= dolu_d;
      if (kabul) begin
        tarihce_q[ptr_q] <= sayi_i;
      end
    end
  end

  assign sonuc_o = sonuc_q;
  assign hazir_o = hazir_q;
  assign dolu_o  = dolu_q;

endmodule

// File: tb/tb_sira_istatistik_birimi.sv
// Directed and randomized bench for the order-statistic filter against a queue-based window model.
module tb_sira_istatistik_birimi;

  localparam int N  = 9;
  localparam int W  = 8;
  localparam int SB = 4;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          etkin_i = 1'b0;
  logic [W-1:0]  sayi_i = '0;
  logic [SB-1:0] sira_i = '0;
  logic          kip_i = 1'b0;
  logic          temizle_i = 1'b0;
  logic [W-1:0]  sonuc_o;
  logic          hazir_o;
  logic          dolu_o;

  sira_istatistik_birimi #(.PIXEL_BIT(W), .PENCERE(N), .SIRA_BIT(SB)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .etkin_i   (etkin_i),
    .sayi_i    (sayi_i),
    .sira_i    (sira_i),
    .kip_i     (kip_i),
    .temizle_i (temizle_i),
    .sonuc_o   (sonuc_o),
    .hazir_o   (hazir_o),
    .dolu_o    (dolu_o)
  );

  always #5 clk_i = ~clk_i;

  int toplam = 0;
  int gecen  = 0;
  int hata   = 0;

  int mq[$];
  bit m_kip;
  bit m_hazir;
  bit m_dolu;
  int m_sonuc;

  function automatic int kth(input int q[$], input int s);
    int a[$];
    int t;
    int k;
    a = q;
    for (int i = 1; i < a.size(); i++) begin
      for (int j = i; j > 0 && a[j-1] > a[j]; j--) begin
        t = a[j]; a[j] = a[j-1]; a[j-1] = t;
      end
    end
    k = (s >= N) ? N - 1 : s;
    return a[k];
  endfunction

  task automatic kontrol(input string etiket, input logic [31:0] gozlenen, input logic [31:0] beklenen);
    toplam++;
    assert (gozlenen === beklenen) gecen++;
    else begin
      hata++;
      $error("FAIL %s gozlenen=%0d beklenen=%0d", etiket, gozlenen, beklenen);
    end
  endtask

  task automatic model(input bit e, input int v, input int s, input bit k, input bit t);
    if (t) begin
      mq.delete();
      m_hazir = 0;
      m_dolu  = 0;
    end else if (e) begin
      if (mq.size() == 0) m_kip = k;
      mq.push_back(v);
      if (!m_kip) begin
        if (mq.size() == N) begin
          m_sonuc = kth(mq, s);
          m_hazir = 1;
          m_dolu  = 1;
          mq.delete();
        end else begin
          m_hazir = 0;
          m_dolu  = 0;
        end
      end else begin
        if (mq.size() > N) void'(mq.pop_front());
        m_hazir = (mq.size() == N);
        m_dolu  = m_hazir;
        if (m_hazir) m_sonuc = kth(mq, s);
      end
    end else begin
      m_hazir = 0;
      m_dolu  = m_kip && (mq.size() == N);
    end
  endtask

  task automatic adim(input bit e, input int v, input int s, input bit k, input bit t);
    @(negedge clk_i);
    rst_i     = 1'b0;
    etkin_i   = e;
    sayi_i    = W'(v);
    sira_i    = SB'(s);
    kip_i     = k;
    temizle_i = t;
    @(posedge clk_i);
    #1;
    model(e, v, s, k, t);
    kontrol("hazir", 32'(hazir_o), 32'(m_hazir));
    kontrol("sonuc", 32'(sonuc_o), 32'(m_sonuc));
    kontrol("dolu",  32'(dolu_o),  32'(m_dolu));
  endtask

  task automatic sifirla();
    @(negedge clk_i);
    rst_i     = 1'b1;
    etkin_i   = 1'b1;
    sayi_i    = W'($urandom);
    temizle_i = 1'b0;
    @(posedge clk_i);
    #1;
    mq.delete();
    m_hazir = 0;
    m_dolu  = 0;
    m_sonuc = 0;
    kontrol("rst_hazir", 32'(hazir_o), 32'd0);
    kontrol("rst_sonuc", 32'(sonuc_o), 32'd0);
    kontrol("rst_dolu",  32'(dolu_o),  32'd0);
  endtask

  task automatic besle(input int d[$], input int s, input bit k);
    foreach (d[i]) adim(1'b1, d[i], s, k, 1'b0);
  endtask

  initial begin
    int ornek[$];
    int kayan[$];
    int dokuzlar[$];
    int e, r;
    ornek    = '{7, 7, 1, 1, 1, 2, 2, 9, 8};
    kayan    = '{7, 7, 1, 1, 1, 2, 2, 9, 8, 0, 9};
    dokuzlar = '{9, 9, 9, 9, 9, 5, 5, 5, 5};
    m_kip = 0; m_hazir = 0; m_dolu = 0; m_sonuc = 0;

    sifirla();
    sifirla();

    // Block mode median, then dolu falls back in the idle cycle.
    besle(ornek, 4, 1'b0);
    kontrol("blok_medyan", 32'(sonuc_o), 32'd2);
    kontrol("blok_dolu_darbe", 32'(dolu_o), 32'd1);
    adim(1'b0, 0, 4, 1'b0, 1'b0);
    kontrol("blok_dolu_sonra", 32'(dolu_o), 32'd0);

    // Back-to-back windows with min, max and clamped rank.
    besle(ornek, 0, 1'b0);
    kontrol("blok_min", 32'(sonuc_o), 32'd1);
    besle(ornek, 8, 1'b0);
    kontrol("blok_max", 32'(sonuc_o), 32'd9);
    besle(ornek, 15, 1'b0);
    kontrol("blok_kirp", 32'(sonuc_o), 32'd9);

    // Gaps after sample 5 freeze state.
    for (int i = 0; i < 5; i++) adim(1'b1, ornek[i], 4, 1'b0, 1'b0);
    adim(1'b0, 3, 4, 1'b1, 1'b0);
    adim(1'b0, 3, 4, 1'b1, 1'b0);
    for (int i = 5; i < 9; i++) adim(1'b1, ornek[i], 4, 1'b1, 1'b0);
    kontrol("bosluk_medyan", 32'(sonuc_o), 32'd2);

    // Sliding mode.
    foreach (kayan[i]) begin
      adim(1'b1, kayan[i], 4, 1'b1, 1'b0);
      if (i >= 8) kontrol("kayan_sonuc", 32'(sonuc_o), 32'd2);
      else        kontrol("kayan_bos", 32'(hazir_o), 32'd0);
    end
    adim(1'b0, 0, 4, 1'b0, 1'b0);
    kontrol("kayan_dolu_kalir", 32'(dolu_o), 32'd1);
    adim(1'b0, 0, 4, 1'b0, 1'b1);

    // Flush mid-window, then a fresh window.
    for (int i = 0; i < 5; i++) adim(1'b1, ornek[i], 3, 1'b0, 1'b0);
    adim(1'b0, 0, 3, 1'b0, 1'b1);
    besle(dokuzlar, 3, 1'b0);
    kontrol("temizle_sonuc", 32'(sonuc_o), 32'd5);
    for (int i = 0; i < 3; i++) adim(1'b1, 200, 4, 1'b0, 1'b0);
    adim(1'b1, 0, 4, 1'b0, 1'b1);
    besle(ornek, 4, 1'b0);
    kontrol("temizle_dusur", 32'(sonuc_o), 32'd2);

    // Reset mid-window at count 6.
    for (int i = 0; i < 6; i++) adim(1'b1, 100 + i, 4, 1'b0, 1'b0);
    sifirla();
    besle(ornek, 4, 1'b0);
    kontrol("rst_sonra_medyan", 32'(sonuc_o), 32'd2);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      r = int'($urandom_range(0, 199));
      if (r < 2) begin
        sifirla();
      end else begin
        e = ($urandom_range(0, 3) != 0) ? 1 : 0;
        adim(e[0],
             (r < 100) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 255)),
             int'($urandom_range(0, 15)),
             $urandom_range(0, 1) == 1,
             r < 6);
      end
    end

    $display("%0d/%0d checks passed", gecen, toplam);
    $finish;
  end

endmodule
